// File: rtl/proc_host_ctrl_if.sv
// Host-link, RAM-port and processor-handshake bundle for the host sequencer.
// master = sequencer side, slave = host/RAM/processor side.
interface proc_host_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) ();
    logic              go;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        status;
    logic              end_process;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  go, in_valid, in_data, in_last, mem_rdata, end_process, out_ready,
        output in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, status,
               out_valid, out_data, out_last, busy, done, err
    );

    modport slave (
        output go, in_valid, in_data, in_last, mem_rdata, end_process, out_ready,
        input  in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, status,
               out_valid, out_data, out_last, busy, done, err
    );
endinterface

// File: rtl/proc_host_ctrl.sv
// Host-side run sequencer: load image into RAM, release the processor, wait for
// end_process (or timeout), then stream a result window back out. All outputs registered.
module proc_host_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DUMP_BASE = 128,
    parameter int unsigned DUMP_LEN  = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    proc_host_ctrl_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DUMP_BASE);

    localparam logic [1:0] STS_HOLD = 2'b00;
    localparam logic [1:0] STS_RUN  = 2'b01;
    localparam logic [1:0] STS_LOAD = 2'b10;
    localparam logic [1:0] STS_FIN  = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StLoad, StRun, StDumpRd, StDumpWait, StDumpOut, StDone
    } state_e;

    state_e            r_state,     w_state;
    logic [ADDR_W-1:0] r_addr,      w_addr;
    logic [ADDR_W-1:0] r_idx,       w_idx;
    logic [CNT_W-1:0]  r_cnt,       w_cnt;
    logic              r_in_ready,  w_in_ready;
    logic              r_mem_we,    w_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr, w_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_mem_re,    w_mem_re;
    logic [ADDR_W-1:0] r_mem_raddr, w_mem_raddr;
    logic [1:0]        r_status,    w_status;
    logic              r_out_valid, w_out_valid;
    logic [DATA_W-1:0] r_out_data,  w_out_data;
    logic              r_out_last,  w_out_last;
    logic              r_busy,      w_busy;
    logic              r_done,      w_done;
    logic              r_err,       w_err;

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_in_ready  = r_in_ready;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_mem_waddr;
        w_mem_wdata = r_mem_wdata;
        w_mem_re    = 1'b0;
        w_mem_raddr = r_mem_raddr;
        w_status    = r_status;
        w_out_valid = r_out_valid;
        w_out_data  = r_out_data;
        w_out_last  = r_out_last;
        w_busy      = r_busy;
        w_done      = r_done;
        w_err       = r_err;

        case (r_state)
            StIdle, StDone: begin
                if (bus.go) begin
                    w_state    = StLoad;
                    w_addr     = '0;
                    w_idx      = '0;
                    w_err      = 1'b0;
                    w_done     = 1'b0;
                    w_busy     = 1'b1;
                    w_in_ready = 1'b1;
                    w_status   = STS_LOAD;
                end
            end
            StLoad: begin
                if (bus.in_valid && r_in_ready) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = r_addr;
                    w_mem_wdata = bus.in_data;
                    w_addr      = r_addr + ADDR_W'(1);
                    // Top address without in_last is an overflow; never wrap onto the image.
                    if (bus.in_last || r_addr == ADDR_MAX) begin
                        w_err      = r_err | ~bus.in_last;
                        w_in_ready = 1'b0;
                        w_status   = STS_RUN;
                        w_cnt      = '0;
                        w_state    = StRun;
                    end
                end
            end
            StRun: begin
                w_cnt = r_cnt + CNT_W'(1);
                if (bus.end_process || r_cnt == CNT_LAST) begin
                    w_err       = r_err | ~bus.end_process;
                    w_status    = STS_FIN;
                    w_idx       = '0;
                    w_mem_re    = 1'b1;
                    w_mem_raddr = BASE;
                    w_state     = StDumpRd;
                end
            end
            StDumpRd: begin
                w_state = StDumpWait;
            end
            StDumpWait: begin
                w_out_data  = bus.mem_rdata;
                w_out_valid = 1'b1;
                w_out_last  = (r_idx == IDX_LAST);
                w_state     = StDumpOut;
            end
            StDumpOut: begin
                if (bus.out_ready) begin
                    w_out_valid = 1'b0;
                    w_out_last  = 1'b0;
                    if (r_out_last) begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = StDone;
                    end else begin
                        w_idx       = r_idx + ADDR_W'(1);
                        w_mem_re    = 1'b1;
                        w_mem_raddr = BASE + r_idx + ADDR_W'(1);
                        w_state     = StDumpRd;
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_raddr <= '0;
            r_status    <= STS_HOLD;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_in_ready  <= w_in_ready;
            r_mem_we    <= w_mem_we;
            r_mem_waddr <= w_mem_waddr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_re    <= w_mem_re;
            r_mem_raddr <= w_mem_raddr;
            r_status    <= w_status;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_last  <= w_out_last;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_raddr = r_mem_raddr;
    assign bus.status    = r_status;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_proc_host_ctrl.sv
// Scoreboard bench for proc_host_ctrl: expected RAM writes and dump words are queued by
// the stimulus and popped by negedge monitors; session-level flags are checked inline.
module tb_proc_host_ctrl;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk;
    logic rst_n;
    logic pre;
    int   checks = 0;
    int   errors = 0;
    int unsigned cyc = 0;
    int unsigned addr_m;
    int unsigned wr_n = 0;
    int unsigned wr_first = 0;
    int unsigned wr_last = 0;

    wr_t         wq[$];
    logic [DW:0] dq[$];
    wr_t         e_wr;
    logic [DW:0] e_dump;
    logic        hold_q = 1'b0;
    logic [DW:0] held_q = '0;
    logic [DW-1:0] ram [0:255];

    proc_host_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    proc_host_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DUMP_BASE (128),
        .DUMP_LEN  (4),
        .TIMEOUT   (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model, 1-cycle read latency; window preloaded while pre is high.
    always @(posedge clk) begin
        if (pre) begin
            ram[128] <= 16'd5;
            ram[129] <= 16'd6;
            ram[130] <= 16'd7;
            ram[131] <= 16'd8;
        end else if (bus.mem_we) begin
            ram[bus.mem_waddr] <= bus.mem_wdata;
        end
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got write %0h<=%0h expected none",
                         bus.mem_waddr, bus.mem_wdata);
            end else begin
                e_wr = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_waddr), 32'(e_wr.a));
                chk("wr_data", 32'(bus.mem_wdata), 32'(e_wr.d));
            end
            if (wr_n == 0) wr_first = cyc;
            wr_last = cyc;
            wr_n++;
        end
        if (bus.mem_re) chk("re_status", 32'(bus.status), 3);
        if (hold_q && bus.out_valid)
            chk("dump_stable", 32'({bus.out_last, bus.out_data}), 32'(held_q));
        if (bus.out_valid && bus.out_ready) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dump_unexpected: got %0h expected none", bus.out_data);
            end else begin
                e_dump = dq.pop_front();
                chk("dump_data", 32'(bus.out_data), 32'(e_dump[DW-1:0]));
                chk("dump_last", 32'(bus.out_last), 32'(e_dump[DW]));
            end
        end
        hold_q <= bus.out_valid && !bus.out_ready;
        held_q <= {bus.out_last, bus.out_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag);
        addr_m = 0;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_status_load"}, 32'(bus.status), 2);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_err_clear"}, 32'(bus.err), 0);
        chk({tag, "_done_clear"}, 32'(bus.done), 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        wq.push_back({AW'(addr_m), d});
        addr_m++;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push_dump(input logic [DW-1:0] base_val);
        for (int k = 0; k < 4; k++) dq.push_back({k == 3, base_val + DW'(k)});
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        ok = bus.out_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: out_valid got 0 expected 1 within 20 cycles", tag);
        end
    endtask

    task automatic recv_dump(input string tag, input int nwords, input int stall_idx,
                             input int stall_len);
        bit ok;
        for (int k = 0; k < nwords; k++) begin
            wait_valid(tag, ok);
            if (!ok) return;
            if (k == stall_idx) repeat (stall_len) tick();
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got no finish expected finish by 100us");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  ok;
        bus.go          = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.end_process = 1'b0;
        bus.out_ready   = 1'b0;
        rst_n           = 1'b0;
        pre             = 1'b1;
        repeat (3) tick();
        chk("rst_status", 32'(bus.status), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_flags", 32'({bus.busy, bus.done, bus.err}), 0);
        chk("rst_mem", 32'({bus.mem_we, bus.mem_re}), 0);
        rst_n = 1'b1;
        pre   = 1'b0;
        tick();

        // Basic session, spurious go in RUN, dump with backpressure on the second word
        start("t1");
        wr_n = 0;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h002A, 1'b1);
        chk("t1_in_ready_drop", 32'(bus.in_ready), 0);
        chk("t1_status_run", 32'(bus.status), 1);
        for (int i = 1; i <= 9; i++) begin
            bus.go = (i == 4);
            tick();
            chk("t1_run_hold", 32'({bus.status, bus.in_ready}), 32'({2'b01, 1'b0}));
        end
        bus.go = 1'b0;
        chk("t1_wr_count", wr_n, 3);
        chk("t1_wr_consec", wr_last - wr_first, 2);
        push_dump(16'd5);
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        chk("t2_status_fin", 32'(bus.status), 3);
        chk("t2_first_re", 32'({bus.mem_re, bus.mem_raddr}), 32'({1'b1, 8'd128}));
        recv_dump("t2", 4, 1, 5);
        chk("t2_done", 32'({bus.done, bus.busy, bus.err}), 32'(3'b100));
        chk("t2_dump_drained", dq.size(), 0);

        // Timeout from DONE
        start("t3");
        send(16'h00FF, 1'b1);
        push_dump(16'd5);
        n = 0;
        while (bus.status == 2'b01 && n < 100) begin
            n++;
            tick();
        end
        chk("t3_run_cycles", n, 20);
        chk("t3_err", 32'(bus.err), 1);
        chk("t3_re_after_timeout", 32'(bus.mem_re), 1);
        recv_dump("t3", 4, -1, 0);
        chk("t3_done_err_held", 32'({bus.done, bus.err}), 32'(2'b11));

        // Overflow with end_process spuriously raised during LOAD
        start("t4");
        for (int i = 0; i < 256; i++) begin
            bus.end_process = (i == 50);
            send(16'h1000 + DW'(i), 1'b0);
            bus.end_process = 1'b0;
            if (i == 50) chk("t5_load_hold", 32'({bus.status, bus.in_ready}), 32'(3'b101));
        end
        chk("t4_in_ready_drop", 32'(bus.in_ready), 0);
        chk("t4_err", 32'(bus.err), 1);
        chk("t4_status_run", 32'(bus.status), 1);
        push_dump(16'h1080);
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        chk("t4_status_fin", 32'(bus.status), 3);

        // Reset while a dump word is presented
        recv_dump("t6a", 1, -1, 0);
        wait_valid("t6b", ok);
        rst_n = 1'b0;
        #1;
        chk("t6_async_status", 32'(bus.status), 0);
        chk("t6_async_out", 32'({bus.out_valid, bus.out_last, bus.out_data}), 0);
        chk("t6_async_flags", 32'({bus.busy, bus.done, bus.err, bus.in_ready}), 0);
        chk("t6_async_mem", 32'({bus.mem_we, bus.mem_re}), 0);
        dq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start("t6");
        send(16'hBEEF, 1'b0);
        send(16'hCAFE, 1'b1);
        chk("t6_status_run", 32'(bus.status), 1);
        push_dump(16'h1080);
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        recv_dump("t6", 4, 2, 3);
        chk("t6_done", 32'({bus.done, bus.err}), 32'(2'b10));

        repeat (3) tick();
        chk("wr_drained", wq.size(), 0);
        chk("dump_drained", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
